// File: rtl/fp_class_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_class_pipe_pkg
// Brief  : Class bit indices and width/bias helpers for the float classifier.
// Rev    : 1.0
// ============================================================================
package fp_class_pipe_pkg;

    localparam int CLS_NORM = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_ZERO = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_QNAN = 4;
    localparam int CLS_SNAN = 5;
    localparam int CLS_N    = 6;

    function automatic int f_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int f_sig_w(input int frac_w);
        return frac_w + 1;
    endfunction

    function automatic int f_uexp_w(input int exp_w);
        return exp_w + 2;
    endfunction

    function automatic int f_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Count width wide enough to hold WIDTH itself (all-zero input).
    function automatic int f_lzc_w(input int width);
        return (width <= 1) ? 2 : $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module : fp_lzc
// Brief  : Combinational leading-zero counter built as a binary tree.
// Rev    : 1.0
// ============================================================================
module fp_lzc
    import fp_class_pipe_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]            i_data,
    output logic [f_lzc_w(WIDTH)-1:0]   o_cnt
);

    localparam int CW = f_lzc_w(WIDTH);
    localparam int L  = CW - 1;
    localparam int P  = 1 << L;

    logic [P-1:0]            w_pad;
    logic [2*P-2:0]          w_v;
    logic [CW*(2*P-1)-1:0]   w_c;

    // Pad the low end with ones so an all-zero input counts exactly WIDTH.
    always_comb begin
        w_pad              = '1;
        w_pad[P-1 -: WIDTH] = i_data;
    end

    // Heap layout: node n has children 2n+1 (MSB side) and 2n+2; leaves start at P-1.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        assign w_v[P-1+i]             = w_pad[P-1-i];
        assign w_c[(P-1+i)*CW +: CW]  = '0;
    end

    for (genvar n = 0; n < P-1; n++) begin : g_node
        localparam int D    = $clog2(n + 2) - 1;
        localparam int HALF = P >> (D + 1);
        logic [CW-1:0] w_cl;
        logic [CW-1:0] w_cr;
        assign w_cl                = w_c[(2*n+1)*CW +: CW];
        assign w_cr                = w_c[(2*n+2)*CW +: CW];
        assign w_v[n]              = w_v[2*n+1] | w_v[2*n+2];
        assign w_c[n*CW +: CW]     = w_v[2*n+1] ? w_cl : (CW'(HALF) + w_cr);
    end

    assign o_cnt = w_v[0] ? w_c[CW-1:0] : CW'(WIDTH);

endmodule
`default_nettype wire

// File: rtl/fp_class_pipe.sv
`default_nettype none
// ============================================================================
// Module : fp_class_pipe
// Brief  : Two-stage IEEE-754 classifier/unpacker with valid/ready stream.
// Rev    : 1.0
// ============================================================================
module fp_class_pipe
    import fp_class_pipe_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [f_width(EXP_W,FRAC_W)-1:0]  in_f,
    input  logic                              in_daz,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sign,
    output logic [f_uexp_w(EXP_W)-1:0]        out_exp,
    output logic [f_sig_w(FRAC_W)-1:0]        out_sig,
    output logic [CLS_N-1:0]                  out_cls
);

    localparam int W      = f_width(EXP_W, FRAC_W);
    localparam int SIG_W  = f_sig_w(FRAC_W);
    localparam int UEXP_W = f_uexp_w(EXP_W);
    localparam int BIAS   = f_bias(EXP_W);
    localparam int LZ_W   = f_lzc_w(FRAC_W);

    localparam logic [UEXP_W-1:0] c_BIAS     = UEXP_W'(BIAS);
    localparam logic [UEXP_W-1:0] c_NEG_BIAS = UEXP_W'(-BIAS);

    // ---------------- handshake ----------------
    logic r_v1;
    logic r_v2;
    logic w_ld1;
    logic w_ld2;
    logic w_acc;

    assign w_ld2     = ~r_v2 | out_ready;
    assign w_ld1     = ~r_v1 | w_ld2;
    assign in_ready  = ~rst & w_ld1;
    assign w_acc     = in_valid & in_ready;
    assign out_valid = r_v2;

    // ---------------- stage 1: decode ----------------
    logic [EXP_W-1:0]   w_exp;
    logic [FRAC_W-1:0]  w_frac;
    logic               w_e_ones;
    logic               w_e_zero;
    logic               w_f_zero;
    logic               w_q;
    logic               w_daz_hit;
    logic [CLS_N-1:0]   w_cls;
    logic [FRAC_W-1:0]  w_frac_s1;
    logic [LZ_W-1:0]    w_lz;

    assign w_exp     = in_f[W-2 -: EXP_W];
    assign w_frac    = in_f[FRAC_W-1:0];
    assign w_e_ones  = &w_exp;
    assign w_e_zero  = ~|w_exp;
    assign w_f_zero  = ~|w_frac;
    assign w_q       = w_frac[FRAC_W-1];
    assign w_daz_hit = in_daz & w_e_zero & ~w_f_zero;
    // A flushed subnormal carries a zero fraction so stage 2 sees a plain zero.
    assign w_frac_s1 = w_daz_hit ? '0 : w_frac;

    always_comb begin
        w_cls           = '0;
        w_cls[CLS_SNAN] = w_e_ones & ~w_f_zero & ~w_q;
        w_cls[CLS_QNAN] = w_e_ones & w_q;
        w_cls[CLS_INF]  = w_e_ones & w_f_zero;
        w_cls[CLS_ZERO] = w_e_zero & w_f_zero;
        w_cls[CLS_SUB]  = w_e_zero & ~w_f_zero;
        w_cls[CLS_NORM] = ~w_e_ones & ~w_e_zero;
        if (w_daz_hit) begin
            w_cls           = '0;
            w_cls[CLS_ZERO] = 1'b1;
        end
    end

    fp_lzc #(
        .WIDTH (FRAC_W)
    ) u_lzc (
        .i_data (w_frac),
        .o_cnt  (w_lz)
    );

    logic               r_sign1;
    logic [EXP_W-1:0]   r_exp1;
    logic [FRAC_W-1:0]  r_frac1;
    logic [CLS_N-1:0]   r_cls1;
    logic [LZ_W-1:0]    r_lz1;

    // ---------------- stage 2: normalise + exponent ----------------
    logic [UEXP_W-1:0]  w_exp2;
    logic [SIG_W-1:0]   w_sig2;

    always_comb begin
        w_exp2 = {2'b00, r_exp1};
        w_sig2 = {1'b0, r_frac1};
        if (r_cls1[CLS_NORM]) begin
            w_exp2 = {2'b00, r_exp1} - c_BIAS;
            w_sig2 = {1'b1, r_frac1};
        end else if (r_cls1[CLS_SUB]) begin
            // (1-BIAS) - (lz+1) folds to -BIAS - lz
            w_exp2 = c_NEG_BIAS - UEXP_W'(r_lz1);
            w_sig2 = {r_frac1, 1'b0} << r_lz1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_sign1  <= 1'b0;
            r_exp1   <= '0;
            r_frac1  <= '0;
            r_cls1   <= '0;
            r_lz1    <= '0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_sig  <= '0;
            out_cls  <= '0;
        end else begin
            if (w_ld1) begin
                r_v1 <= w_acc;
                if (w_acc) begin
                    r_sign1 <= in_f[W-1];
                    r_exp1  <= w_exp;
                    r_frac1 <= w_frac_s1;
                    r_cls1  <= w_cls;
                    r_lz1   <= w_lz;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    out_sign <= r_sign1;
                    out_exp  <= w_exp2;
                    out_sig  <= w_sig2;
                    out_cls  <= r_cls1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_class_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_class_pipe
// Brief  : Directed checks of the classifier in half, single and double formats.
// Rev    : 1.0
// ============================================================================
module tb_fp_class_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // half precision instance
    logic        h_in_valid = 1'b0, h_in_ready, h_in_daz = 1'b0;
    logic [15:0] h_in_f = '0;
    logic        h_out_valid, h_out_ready = 1'b1, h_out_sign;
    logic [6:0]  h_out_exp;
    logic [10:0] h_out_sig;
    logic [5:0]  h_out_cls;

    fp_class_pipe #(.EXP_W(5), .FRAC_W(10)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_f(h_in_f), .in_daz(h_in_daz), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out_sign(h_out_sign), .out_exp(h_out_exp),
        .out_sig(h_out_sig), .out_cls(h_out_cls)
    );

    // single precision instance
    logic        s_in_valid = 1'b0, s_in_ready;
    logic [31:0] s_in_f = '0;
    logic        s_out_valid, s_out_sign;
    logic [9:0]  s_out_exp;
    logic [23:0] s_out_sig;
    logic [5:0]  s_out_cls;

    fp_class_pipe #(.EXP_W(8), .FRAC_W(23)) u_single (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_f(s_in_f), .in_daz(1'b0), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_sign(s_out_sign), .out_exp(s_out_exp),
        .out_sig(s_out_sig), .out_cls(s_out_cls)
    );

    // double precision instance
    logic        d_in_valid = 1'b0, d_in_ready;
    logic [63:0] d_in_f = '0;
    logic        d_out_valid, d_out_sign;
    logic [12:0] d_out_exp;
    logic [52:0] d_out_sig;
    logic [5:0]  d_out_cls;

    fp_class_pipe #(.EXP_W(11), .FRAC_W(52)) u_double (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_f(d_in_f), .in_daz(1'b0), .out_valid(d_out_valid),
        .out_ready(1'b1), .out_sign(d_out_sign), .out_exp(d_out_exp),
        .out_sig(d_out_sig), .out_cls(d_out_cls)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // half vectors: f, daz, sign, exp (7b two's complement), sig, cls
    logic [15:0] v_f   [12] = '{16'h3C00, 16'hC000, 16'h0001, 16'h0200, 16'h03FF, 16'h7E00,
                                16'h7C01, 16'h7C00, 16'h8000, 16'h0001, 16'h3C00, 16'h3555};
    logic        v_daz [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    logic        v_sgn [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [6:0]  v_exp [12] = '{7'h00, 7'h01, 7'h68, 7'h71, 7'h71, 7'h1F,
                                7'h1F, 7'h1F, 7'h00, 7'h00, 7'h00, 7'h7E};
    logic [10:0] v_sig [12] = '{11'h400, 11'h400, 11'h400, 11'h400, 11'h7FE, 11'h200,
                                11'h001, 11'h000, 11'h000, 11'h000, 11'h400, 11'h555};
    logic [5:0]  v_cls [12] = '{6'h01, 6'h01, 6'h02, 6'h02, 6'h02, 6'h10,
                                6'h20, 6'h08, 6'h04, 6'h04, 6'h01, 6'h01};

    task automatic run_half(input int k);
        bit seen = 0;
        @(negedge clk);
        h_in_f     = v_f[k];
        h_in_daz   = v_daz[k];
        h_in_valid = 1'b1;
        @(negedge clk);
        h_in_valid = 1'b0;
        h_in_daz   = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (h_out_valid) seen = 1;
            else @(negedge clk);
        end
        chk($sformatf("h%0d_valid", k), 64'(seen), 64'd1);
        if (seen) begin
            chk($sformatf("h%0d_sign", k), 64'(h_out_sign), 64'(v_sgn[k]));
            chk($sformatf("h%0d_exp", k),  64'(h_out_exp),  64'(v_exp[k]));
            chk($sformatf("h%0d_sig", k),  64'(h_out_sig),  64'(v_sig[k]));
            chk($sformatf("h%0d_cls", k),  64'(h_out_cls),  64'(v_cls[k]));
        end
    endtask

    task automatic run_single(input logic [31:0] f, input logic [9:0] e, input logic [23:0] s,
                              input string tag);
        bit seen = 0;
        @(negedge clk);
        s_in_f = f; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (s_out_valid) seen = 1;
            else @(negedge clk);
        end
        chk({tag, "_valid"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_exp"}, 64'(s_out_exp), 64'(e));
            chk({tag, "_sig"}, 64'(s_out_sig), 64'(s));
        end
    endtask

    task automatic run_double(input logic [63:0] f, input logic [12:0] e, input logic [52:0] s,
                              input string tag);
        bit seen = 0;
        @(negedge clk);
        d_in_f = f; d_in_valid = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (d_out_valid) seen = 1;
            else @(negedge clk);
        end
        chk({tag, "_valid"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_exp"}, 64'(d_out_exp), 64'(e));
            chk({tag, "_sig"}, 64'(d_out_sig), 64'(s));
            chk({tag, "_cls"}, 64'(d_out_cls), 64'h02);
        end
    endtask

    initial begin
        int acc;
        int got;
        int late;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(h_out_valid), 64'd0);
        chk("rst_in_ready",  64'(h_in_ready),  64'd0);
        chk("rst_out_data",  64'({h_out_sign, h_out_exp, h_out_sig, h_out_cls}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(h_in_ready), 64'd1);

        for (int k = 0; k < 12; k++) run_half(k);

        run_single(32'h0000_0001, 10'h36B, 24'h80_0000, "s_minsub");
        run_single(32'h3F80_0000, 10'h000, 24'h80_0000, "s_one");
        run_double(64'h0000_0000_0000_0001, 13'h1BCE, 53'h10_0000_0000_0000, "d_minsub");

        // backpressure stream: op i has exponent i and fraction i
        acc = 0;
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            h_out_ready = !(c >= 2 && c <= 6);
            h_in_valid  = (acc < 6);
            h_in_f      = 16'h3C00 + 16'(acc) * 16'h0401;
            #1;
            if (c == 2) chk("bp_ready_c2", 64'(h_in_ready), 64'd1);
            if (c == 4) chk("bp_ready_c4", 64'(h_in_ready), 64'd0);
            if (h_out_valid) begin
                chk($sformatf("bp_exp_c%0d", c), 64'(h_out_exp), 64'(got));
                chk($sformatf("bp_sig_c%0d", c), 64'(h_out_sig), 64'h400 + 64'(got));
                if (h_out_ready) got++;
            end
            if (h_in_valid && h_in_ready) acc++;
        end
        h_in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd6);
        chk("bp_emitted",  64'(got), 64'd6);
        chk("bp_drained",  64'(h_out_valid), 64'd0);

        // reset with two operands in flight
        @(negedge clk);
        h_out_ready = 1'b0;
        h_in_f = 16'h3C00; h_in_valid = 1'b1;
        @(negedge clk);
        h_in_f = 16'h4000;
        @(negedge clk);
        h_in_valid = 1'b0;
        chk("mid_pre_valid", 64'(h_out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(h_out_valid), 64'd0);
        chk("mid_rst_ready", 64'(h_in_ready),  64'd0);
        chk("mid_rst_cls",   64'(h_out_cls),   64'd0);
        rst = 1'b0;
        h_out_ready = 1'b1;
        late = 0;
        repeat (4) begin
            @(negedge clk);
            if (h_out_valid) late++;
        end
        chk("mid_discarded", 64'(late), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
